// File: rtl/ram_loader_if.sv
// Loader-side signal bundle: byte-source handshake, shared bus and RAM/address-register controls.
// master = the loader itself, slave = byte source plus bus/RAM environment.
interface ram_loader_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
);
    logic                  start;
    logic [DATA_WIDTH-1:0] byte_in;
    logic                  byte_valid;
    logic                  byte_ready;
    logic [DATA_WIDTH-1:0] bus_in;
    logic [DATA_WIDTH-1:0] bus_out;
    logic                  bus_drive;
    logic                  load_addr_reg;
    logic                  ram_write_n;
    logic                  ram_read;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  busy;
    logic                  done;
    logic                  error;

    modport master (
        input  start, byte_in, byte_valid, bus_in,
        output byte_ready, bus_out, bus_drive, load_addr_reg, ram_write_n,
               ram_read, addr, busy, done, error
    );

    modport slave (
        output start, byte_in, byte_valid, bus_in,
        input  byte_ready, bus_out, bus_drive, load_addr_reg, ram_write_n,
               ram_read, addr, busy, done, error
    );
endinterface

// File: rtl/ram_loader.sv
// Streams program bytes into the RAM: per byte, load the address register, then strobe a write.
// Define RAM_LOADER_VERIFY_EN to add a read-back cycle after each write that stops on mismatch.
module ram_loader #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int START_ADDR = 0,
    parameter int LAST_ADDR  = 15
) (
    input logic          clk,
    input logic          clear,
    ram_loader_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_BYTE, S_SET_ADDR, S_WRITE, S_READ, S_DONE, S_ERROR
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] C_START_ADDR = ADDR_WIDTH'(START_ADDR);
    localparam logic [ADDR_WIDTH-1:0] C_LAST_ADDR  = ADDR_WIDTH'(LAST_ADDR);

    state_t                r_state;
    state_t                w_state_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] w_addr_next;
    logic [DATA_WIDTH-1:0] r_data;
    logic [DATA_WIDTH-1:0] w_data_next;
    logic                  w_at_last;

    assign w_at_last = (r_addr == C_LAST_ADDR);

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_state <= S_IDLE;
            r_addr  <= C_START_ADDR;
            r_data  <= '0;
        end else begin
            r_state <= w_state_next;
            r_addr  <= w_addr_next;
            r_data  <= w_data_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_addr_next  = r_addr;
        w_data_next  = r_data;
        case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (bus.start) begin
                    w_state_next = S_WAIT_BYTE;
                    w_addr_next  = C_START_ADDR;
                end
            end
            // byte_ready is high for the whole state, so valid alone completes the handshake
            S_WAIT_BYTE: begin
                if (bus.byte_valid) begin
                    w_data_next  = bus.byte_in;
                    w_state_next = S_SET_ADDR;
                end
            end
            S_SET_ADDR: w_state_next = S_WRITE;
            S_WRITE: begin
`ifdef RAM_LOADER_VERIFY_EN
                w_state_next = S_READ;
`else
                if (w_at_last) begin
                    w_state_next = S_DONE;
                end else begin
                    w_state_next = S_WAIT_BYTE;
                    w_addr_next  = r_addr + ADDR_WIDTH'(1);
                end
`endif
            end
`ifdef RAM_LOADER_VERIFY_EN
            // On mismatch addr is left on the failing location for diagnosis
            S_READ: begin
                if (bus.bus_in != r_data) begin
                    w_state_next = S_ERROR;
                end else if (w_at_last) begin
                    w_state_next = S_DONE;
                end else begin
                    w_state_next = S_WAIT_BYTE;
                    w_addr_next  = r_addr + ADDR_WIDTH'(1);
                end
            end
`endif
            default: w_state_next = S_IDLE;
        endcase
    end

    // Strobes decode only the registered state, giving full-cycle glitch-free pulses
    always_comb begin
        bus.byte_ready    = 1'b0;
        bus.bus_drive     = 1'b0;
        bus.bus_out       = '0;
        bus.load_addr_reg = 1'b0;
        bus.ram_write_n   = 1'b1;
        bus.ram_read      = 1'b0;
        bus.busy          = 1'b0;
        bus.done          = 1'b0;
        case (r_state)
            S_WAIT_BYTE: begin
                bus.byte_ready = 1'b1;
                bus.busy       = 1'b1;
            end
            S_SET_ADDR: begin
                bus.bus_drive     = 1'b1;
                bus.bus_out       = DATA_WIDTH'(r_addr);
                bus.load_addr_reg = 1'b1;
                bus.busy          = 1'b1;
            end
            S_WRITE: begin
                bus.bus_drive   = 1'b1;
                bus.bus_out     = r_data;
                bus.ram_write_n = 1'b0;
                bus.busy        = 1'b1;
            end
`ifdef RAM_LOADER_VERIFY_EN
            S_READ: begin
                bus.ram_read = 1'b1;
                bus.busy     = 1'b1;
            end
`endif
            S_DONE: bus.done = 1'b1;
            default: ;
        endcase
    end

    assign bus.addr = r_addr;

`ifdef RAM_LOADER_VERIFY_EN
    assign bus.error = (r_state == S_ERROR);
`else
    logic w_unused_bus_in;
    assign w_unused_bus_in = ^bus.bus_in;
    assign bus.error       = 1'b0;
`endif
endmodule

// File: tb/tb_ram_loader.sv
// Randomized bench for ram_loader: two instances (full 0..15 range and 12..15) checked every
// cycle against a transaction-level model, with a RAM/address-register model on the bus side.
module tb_ram_loader;
`ifdef RAM_LOADER_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif
    localparam int GAP = VERIFY ? 4 : 3;

    logic clk = 1'b0;
    logic clear;
    always #5 clk = ~clk;

    logic       tb_start[2];
    logic [7:0] tb_byte[2];
    logic       tb_valid[2];
    logic [7:0] tb_bus_in[2];
    logic       ob_ready[2], ob_drive[2], ob_ld[2], ob_wn[2], ob_rd[2];
    logic       ob_busy[2], ob_done[2], ob_err[2];
    logic [7:0] ob_bus[2];
    logic [3:0] ob_addr[2];

    ram_loader_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) if0 ();
    ram_loader_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) if1 ();

    ram_loader #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .START_ADDR(0), .LAST_ADDR(15))
        dut0 (.clk(clk), .clear(clear), .bus(if0));
    ram_loader #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .START_ADDR(12), .LAST_ADDR(15))
        dut1 (.clk(clk), .clear(clear), .bus(if1));

    assign if0.start = tb_start[0];  assign if1.start = tb_start[1];
    assign if0.byte_in = tb_byte[0]; assign if1.byte_in = tb_byte[1];
    assign if0.byte_valid = tb_valid[0]; assign if1.byte_valid = tb_valid[1];
    assign if0.bus_in = tb_bus_in[0]; assign if1.bus_in = tb_bus_in[1];
    assign ob_ready[0] = if0.byte_ready;   assign ob_ready[1] = if1.byte_ready;
    assign ob_drive[0] = if0.bus_drive;    assign ob_drive[1] = if1.bus_drive;
    assign ob_ld[0]    = if0.load_addr_reg; assign ob_ld[1]   = if1.load_addr_reg;
    assign ob_wn[0]    = if0.ram_write_n;  assign ob_wn[1]    = if1.ram_write_n;
    assign ob_rd[0]    = if0.ram_read;     assign ob_rd[1]    = if1.ram_read;
    assign ob_busy[0]  = if0.busy;         assign ob_busy[1]  = if1.busy;
    assign ob_done[0]  = if0.done;         assign ob_done[1]  = if1.done;
    assign ob_err[0]   = if0.error;        assign ob_err[1]   = if1.error;
    assign ob_bus[0]   = if0.bus_out;      assign ob_bus[1]   = if1.bus_out;
    assign ob_addr[0]  = if0.addr;         assign ob_addr[1]  = if1.addr;

    // Model: per instance, whether a sequence runs, cycles elapsed since the current byte was taken
    bit         m_busy[2];
    int         m_k[2];
    logic [3:0] m_addr[2];
    logic [7:0] m_byte[2];
    bit         m_done[2], m_err[2];

    logic [7:0] mem[2][16];
    logic [3:0] areg[2];
    int         wr_cnt[2], hs_cnt[2];
    int         hs_cyc[2][16];
    bit         hs_flag[2];
    bit         corrupt_en[2];
    int         cyc;

    logic [7:0] src_mem[2][16];
    int         src_len[2], src_idx[2], stall_at[2], stall_len[2], stall_cnt[2];
    bit         rand_gap[2];

    int n_cmp, n_fail;

    function automatic logic [3:0] sa(input int k);
        return (k == 0) ? 4'd0 : 4'd12;
    endfunction

    task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s inst%0d t=%0t actual=0x%0h required=0x%0h", name, k, $time, act, req);
        end
    endtask

    always_comb begin
        for (int k = 0; k < 2; k++)
            tb_bus_in[k] = (corrupt_en[k] && areg[k] == 4'd5) ? 8'hFF : mem[k][areg[k]];
    end

    task automatic model_reset(input int k);
        m_busy[k] = 1'b0; m_k[k] = 0; m_addr[k] = sa(k);
        m_done[k] = 1'b0; m_err[k] = 1'b0; m_byte[k] = 8'h00;
    endtask

    task automatic byte_finished(input int k);
        m_k[k] = 0;
        if (m_addr[k] == 4'd15) begin
            m_busy[k] = 1'b0; m_done[k] = 1'b1;
        end else begin
            m_addr[k] = m_addr[k] + 4'd1;
        end
    endtask

    task automatic model_step(input int k);
        if (!m_busy[k]) begin
            if (tb_start[k]) begin
                m_busy[k] = 1'b1; m_k[k] = 0; m_addr[k] = sa(k);
                m_done[k] = 1'b0; m_err[k] = 1'b0;
            end
        end else begin
            case (m_k[k])
                0: if (tb_valid[k]) begin m_byte[k] = tb_byte[k]; m_k[k] = 1; end
                1: m_k[k] = 2;
                2: if (VERIFY) m_k[k] = 3; else byte_finished(k);
                default: begin
                    if (tb_bus_in[k] != m_byte[k]) begin
                        m_busy[k] = 1'b0; m_err[k] = 1'b1; m_k[k] = 0;
                    end else begin
                        byte_finished(k);
                    end
                end
            endcase
        end
    endtask

    task automatic compare_cycle(input int k);
        logic e_drive;
        e_drive = m_busy[k] && (m_k[k] == 1 || m_k[k] == 2);
        check("busy", k, 32'(ob_busy[k]), 32'(m_busy[k]));
        check("byte_ready", k, 32'(ob_ready[k]), 32'(m_busy[k] && m_k[k] == 0));
        check("load_addr_reg", k, 32'(ob_ld[k]), 32'(m_busy[k] && m_k[k] == 1));
        check("ram_write_n", k, 32'(ob_wn[k]), 32'(!(m_busy[k] && m_k[k] == 2)));
        check("ram_read", k, 32'(ob_rd[k]), 32'(m_busy[k] && m_k[k] == 3));
        check("bus_drive", k, 32'(ob_drive[k]), 32'(e_drive));
        check("addr", k, 32'(ob_addr[k]), 32'(m_addr[k]));
        check("done", k, 32'(ob_done[k]), 32'(m_done[k]));
        check("error", k, 32'(ob_err[k]), 32'(m_err[k]));
        if (e_drive)
            check("bus_out", k, 32'(ob_bus[k]), (m_k[k] == 1) ? 32'(m_addr[k]) : 32'(m_byte[k]));
        else if (clear)
            check("bus_out_rst", k, 32'(ob_bus[k]), 32'd0);
    endtask

    // Single compare process; also plays the RAM and address register on the bus side
    always @(negedge clk) begin
        cyc++;
        for (int k = 0; k < 2; k++) begin
            if (clear) model_reset(k);
            compare_cycle(k);
            hs_flag[k] = !clear && ob_ready[k] && tb_valid[k];
            if (!clear) begin
                if (ob_ld[k]) areg[k] = ob_bus[k][3:0];
                if (!ob_wn[k]) begin
                    mem[k][areg[k]] = ob_bus[k];
                    wr_cnt[k]++;
                end
                if (hs_flag[k]) begin
                    if (hs_cnt[k] < 16) hs_cyc[k][hs_cnt[k]] = cyc;
                    hs_cnt[k]++;
                end
                model_step(k);
            end
        end
    end

    // Byte source: presents src_mem in order, advancing after each completed handshake
    initial begin
        forever begin
            @(posedge clk); #2;
            for (int k = 0; k < 2; k++) begin
                if (hs_flag[k]) begin
                    src_idx[k]++;
                    if (src_idx[k] == stall_at[k]) stall_cnt[k] = stall_len[k];
                end
                if (stall_cnt[k] > 0) begin
                    stall_cnt[k]--;
                    tb_valid[k] = 1'b0;
                end else if (src_idx[k] < src_len[k]) begin
                    tb_valid[k] = rand_gap[k] ? ($urandom_range(0, 2) != 0) : 1'b1;
                end else begin
                    tb_valid[k] = 1'b0;
                end
                tb_byte[k] = (tb_valid[k] && src_idx[k] < src_len[k]) ? src_mem[k][src_idx[k]] : 8'($urandom);
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic pulse_start(input int k);
        tb_start[k] = 1'b1; tick(); tb_start[k] = 1'b0;
    endtask

    task automatic load_src(input int k, input bit incr, input int len);
        for (int i = 0; i < len; i++) src_mem[k][i] = incr ? 8'h10 + 8'(i) : 8'($urandom);
        src_len[k] = len; src_idx[k] = 0; stall_at[k] = -1; stall_cnt[k] = 0;
    endtask

    task automatic sb_clear(input int k);
        wr_cnt[k] = 0; hs_cnt[k] = 0;
        for (int a = 0; a < 16; a++) mem[k][a] = 8'h00;
    endtask

    task automatic wait_end(input int k, input int budget);
        int n;
        n = 0;
        while (!(ob_done[k] || ob_err[k]) && n < budget) begin tick(); n++; end
        check("seq_end_timeout", k, 32'(ob_done[k] || ob_err[k]), 32'd1);
        $display("inst%0d sequence end: writes=%0d done=%0d error=%0d addr=%0d",
                 k, wr_cnt[k], ob_done[k], ob_err[k], ob_addr[k]);
    endtask

    task automatic check_mem(input string name, input int k, input int len);
        for (int i = 0; i < len; i++)
            check(name, k, 32'(mem[k][sa(k) + 4'(i)]), 32'(src_mem[k][i]));
    endtask

    initial begin
        int n;
        n_cmp = 0; n_fail = 0; cyc = 0; clear = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tb_start[k] = 1'b0; tb_valid[k] = 1'b0; tb_byte[k] = 8'h00;
            corrupt_en[k] = 1'b0; rand_gap[k] = 1'b0; stall_len[k] = 0;
            areg[k] = 4'd0; hs_flag[k] = 1'b0;
            load_src(k, 1'b1, 0); sb_clear(k); model_reset(k);
        end
        repeat (3) tick();
        clear = 1'b0;
        tick();
        check("rst_busy", 0, 32'(ob_busy[0]), 32'd0);
        check("rst_write_n", 0, 32'(ob_wn[0]), 32'd1);
        check("rst_addr", 0, 32'(ob_addr[0]), 32'd0);
        check("rst_addr", 1, 32'(ob_addr[1]), 32'd12);
        check("rst_done", 0, 32'(ob_done[0]), 32'd0);

        // Asynchronous clear in the middle of the address cycle
        load_src(0, 1'b1, 16); sb_clear(0); pulse_start(0);
        n = 0;
        while (!ob_ld[0] && n < 20) begin tick(); n++; end
        check("t1_reach_set_addr", 0, 32'(ob_ld[0]), 32'd1);
        clear = 1'b1; #1;
        check("t1_busy", 0, 32'(ob_busy[0]), 32'd0);
        check("t1_write_n", 0, 32'(ob_wn[0]), 32'd1);
        check("t1_load_addr", 0, 32'(ob_ld[0]), 32'd0);
        check("t1_drive", 0, 32'(ob_drive[0]), 32'd0);
        check("t1_addr", 0, 32'(ob_addr[0]), 32'd0);
        tick(); clear = 1'b0; tick();

        // Full 16-byte stream with valid held high
        load_src(0, 1'b1, 16); sb_clear(0); pulse_start(0);
        wait_end(0, 200);
        check("t2_done", 0, 32'(ob_done[0]), 32'd1);
        check("t2_writes", 0, 32'(wr_cnt[0]), 32'd16);
        for (int i = 0; i < 16; i++) check("t2_mem", 0, 32'(mem[0][i]), 32'h10 + 32'(i));
        for (int i = 0; i < 15; i++) check("t2_accept_gap", 0, 32'(hs_cyc[0][i+1] - hs_cyc[0][i]), 32'(GAP));

        // Source stalls for 5 cycles after the third byte
        load_src(0, 1'b0, 16); stall_at[0] = 3; stall_len[0] = 5; sb_clear(0); pulse_start(0);
        n = 0;
        while (hs_cnt[0] < 3 && n < 100) begin tick(); n++; end
        check("t3_three_bytes", 0, 32'(hs_cnt[0] >= 3), 32'd1);
        repeat (4) tick();
        check("t3_stall_addr", 0, 32'(ob_addr[0]), 32'd3);
        check("t3_stall_ready", 0, 32'(ob_ready[0]), 32'd1);
        check("t3_stall_write_n", 0, 32'(ob_wn[0]), 32'd1);
        wait_end(0, 300);
        check("t3_done", 0, 32'(ob_done[0]), 32'd1);
        check("t3_writes", 0, 32'(wr_cnt[0]), 32'd16);
        check_mem("t3_mem", 0, 16);

        // start while busy is ignored; start in DONE restarts from the first address
        load_src(0, 1'b0, 16); sb_clear(0); pulse_start(0);
        n = 0;
        while (ob_addr[0] != 4'd7 && n < 100) begin tick(); n++; end
        check("t4_reach_addr7", 0, 32'(ob_addr[0]), 32'd7);
        pulse_start(0);
        wait_end(0, 300);
        check("t4_done", 0, 32'(ob_done[0]), 32'd1);
        check("t4_writes", 0, 32'(wr_cnt[0]), 32'd16);
        check_mem("t4_mem", 0, 16);
        load_src(0, 1'b0, 16); sb_clear(0); pulse_start(0);
        check("t4_restart_done", 0, 32'(ob_done[0]), 32'd0);
        check("t4_restart_busy", 0, 32'(ob_busy[0]), 32'd1);
        check("t4_restart_addr", 0, 32'(ob_addr[0]), 32'd0);
        wait_end(0, 300);
        check_mem("t4_reload_mem", 0, 16);

        // Narrow range 12..15 must not wrap to 0
        load_src(1, 1'b0, 4); sb_clear(1); pulse_start(1);
        wait_end(1, 100);
        check("t5_done", 1, 32'(ob_done[1]), 32'd1);
        check("t5_writes", 1, 32'(wr_cnt[1]), 32'd4);
        check("t5_addr0_untouched", 1, 32'(mem[1][0]), 32'd0);
        check_mem("t5_mem", 1, 4);

        // Random bytes, random valid gaps, random start noise while busy, both instances at once
        for (int rep = 0; rep < 3; rep++) begin
            load_src(0, 1'b0, 16); load_src(1, 1'b0, 4);
            rand_gap[0] = 1'b1; rand_gap[1] = 1'b1;
            sb_clear(0); sb_clear(1);
            tb_start[0] = 1'b1; tb_start[1] = 1'b1; tick();
            n = 0;
            while (!(ob_done[0] && ob_done[1]) && n < 600) begin
                for (int k = 0; k < 2; k++) tb_start[k] = ob_busy[k] && ($urandom_range(0, 3) == 0);
                tick(); n++;
            end
            tb_start[0] = 1'b0; tb_start[1] = 1'b0;
            rand_gap[0] = 1'b0; rand_gap[1] = 1'b0;
            for (int k = 0; k < 2; k++) begin
                wait_end(k, 10);
                check("rnd_writes", k, 32'(wr_cnt[k]), (k == 0) ? 32'd16 : 32'd4);
                check_mem("rnd_mem", k, (k == 0) ? 16 : 4);
            end
        end

        // RAM returns 0xFF at address 5: only a verifying loader notices
        corrupt_en[0] = 1'b1;
        load_src(0, 1'b1, 16); sb_clear(0); pulse_start(0);
        wait_end(0, 300);
        check("t6_error", 0, 32'(ob_err[0]), VERIFY ? 32'd1 : 32'd0);
        check("t6_done", 0, 32'(ob_done[0]), VERIFY ? 32'd0 : 32'd1);
        check("t6_addr", 0, 32'(ob_addr[0]), VERIFY ? 32'd5 : 32'd15);
        check("t6_writes", 0, 32'(wr_cnt[0]), VERIFY ? 32'd6 : 32'd16);
        repeat (5) tick();
        check("t6_no_more_writes", 0, 32'(wr_cnt[0]), VERIFY ? 32'd6 : 32'd16);
        check("t6_error_held", 0, 32'(ob_err[0]), VERIFY ? 32'd1 : 32'd0);
        corrupt_en[0] = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog t=%0t actual=running required=finished", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
